// File: rtl/skew_cal_seq_pkg.sv
// Shared types, FSM encodings and the rounding helper for the skew calibration sequencer.
package skew_cal_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEL      = 3'd1;
    localparam logic [2:0] ST_SETTLE   = 3'd2;
    localparam logic [2:0] ST_WAIT_GEN = 3'd3;
    localparam logic [2:0] ST_RUN      = 3'd4;
    localparam logic [2:0] ST_RELEASE  = 3'd5;
    localparam logic [2:0] ST_STORE    = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    typedef logic [2:0] state_t;

    localparam int RES_CODE_W = 16;

    typedef struct packed {
        logic [RES_CODE_W-1:0] code;
        logic                  valid;
        logic                  err;
    } res_t;

    // Round half up; the max accumulator value rounds to exactly the max code, so no saturation.
    function automatic logic [31:0] avg_round(input logic [31:0] acc, input int log2);
        logic [31:0] half;
        half = (log2 == 0) ? 32'd0 : (32'd1 << (log2 - 1));
        return (acc + half) >> log2;
    endfunction

endpackage

// File: rtl/skew_cal_seq_if.sv
// Handshake between the sequencer and the skew_mes_ctl / stb_gen measurement pair.
interface skew_cal_seq_if #(
    parameter int CODE_W = 10
);
    logic              mes_run_o;
    logic              mes_rdy_i;
    logic              mes_err_i;
    logic [CODE_W-1:0] mes_code_i;
    logic              gen_rdy_i;

    modport master (
        output mes_run_o,
        input  mes_rdy_i, mes_err_i, mes_code_i, gen_rdy_i
    );

    modport slave (
        input  mes_run_o,
        output mes_rdy_i, mes_err_i, mes_code_i, gen_rdy_i
    );
endinterface

// File: rtl/skew_cal_acc.sv
// Per-channel accumulator and rep counter producing the rounded average code.
module skew_cal_acc
    import skew_cal_pkg::*;
#(
    parameter int CODE_W   = 10,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              clear_i,
    input  logic              add_i,
    input  logic [CODE_W-1:0] code_i,
    output logic [CODE_W-1:0] result_o,
    output logic              reps_done_o
);
    localparam int ACC_W = CODE_W + AVG_LOG2;
    localparam int REP_W = AVG_LOG2 + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [REP_W-1:0] rep_q, rep_d;

    always_comb begin
        acc_d = acc_q;
        rep_d = rep_q;
        if (clear_i) begin
            acc_d = '0;
            rep_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + ACC_W'(code_i);
            rep_d = rep_q + REP_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            acc_q <= '0;
            rep_q <= '0;
        end else begin
            acc_q <= acc_d;
            rep_q <= rep_d;
        end
    end

    assign reps_done_o = (rep_q == REP_W'(1 << AVG_LOG2));
    assign result_o    = CODE_W'(avg_round(32'(acc_q), AVG_LOG2));

endmodule

// File: rtl/skew_cal_seq.sv
// Calibration sequencer: sweeps masked channels through the measure unit and stores
// one rounded average code plus valid/error status per channel.
module skew_cal_seq
    import skew_cal_pkg::*;
#(
    parameter  int N_CH       = 8,
    parameter  int CODE_W     = 10,
    parameter  int AVG_LOG2   = 2,
    parameter  int SETTLE_CYC = 16,
    parameter  int TMO_CYC    = 2**20 - 1,
    localparam int CH_W       = $clog2(N_CH)
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [N_CH-1:0]   ch_mask_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CH_W-1:0]   ch_sel_o,
    input  logic [CH_W-1:0]   rd_addr_i,
    output logic [CODE_W-1:0] rd_code_o,
    output logic [N_CH-1:0]   res_valid_o,
    output logic [N_CH-1:0]   res_err_o,
    skew_cal_seq_if.master    mes
);
    localparam int CNT_MAX = (TMO_CYC > SETTLE_CYC) ? TMO_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TMO_CYC - 1);

    state_t            state_q, state_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              err_q, err_d;
    logic [N_CH-1:0]   valid_q, valid_d;
    logic [N_CH-1:0]   rerr_q, rerr_d;
    logic [CODE_W-1:0] codes_q [N_CH];

    logic              sel_found;
    logic [CH_W-1:0]   sel_ch;
    logic              acc_clear, acc_add, store_wr, reps_done;
    logic [CODE_W-1:0] acc_result;

    skew_cal_acc #(
        .CODE_W  (CODE_W),
        .AVG_LOG2(AVG_LOG2)
    ) u_acc (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .clear_i    (acc_clear),
        .add_i      (acc_add),
        .code_i     (mes.mes_code_i),
        .result_o   (acc_result),
        .reps_done_o(reps_done)
    );

    // Lowest set bit of the remaining mask wins.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        valid_d   = valid_q;
        rerr_d    = rerr_q;
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        store_wr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mask_d  = ch_mask_i;
                    valid_d = '0;
                    rerr_d  = '0;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                if (!sel_found) begin
                    state_d = ST_DONE;
                end else begin
                    ch_d      = sel_ch;
                    acc_clear = 1'b1;
                    err_d     = 1'b0;
                    cnt_d     = SETTLE_LD;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_WAIT_GEN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_WAIT_GEN: begin
                if (mes.gen_rdy_i) begin
                    cnt_d   = TMO_LD;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Error and timeout take precedence over a simultaneous ready.
                if (mes.mes_err_i || (cnt_q == '0)) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else if (mes.mes_rdy_i) begin
                    acc_add = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!mes.mes_rdy_i && !mes.mes_err_i) begin
                    if (!reps_done && !err_q) begin
                        cnt_d   = TMO_LD;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_STORE;
                    end
                end
            end
            ST_STORE: begin
                if (err_q) begin
                    rerr_d[ch_q] = 1'b1;
                end else begin
                    valid_d[ch_q] = 1'b1;
                    store_wr      = 1'b1;
                end
                mask_d[ch_q] = 1'b0;
                state_d      = ST_SEL;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) begin
            state_d  = ST_IDLE;
            valid_d  = valid_q;
            rerr_d   = rerr_q;
            store_wr = 1'b0;
        end
    end

    // Registered run level follows the next state so it rises with the first RUN cycle.
    assign run_d = (state_d == ST_RUN);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= '0;
            rerr_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            rerr_q  <= rerr_d;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            codes_q <= '{default: '0};
        end else if (store_wr) begin
            codes_q[ch_q] <= acc_result;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign ch_sel_o      = ch_q;
    assign mes.mes_run_o = run_q;
    assign rd_code_o     = codes_q[rd_addr_i];
    assign res_valid_o   = valid_q;
    assign res_err_o     = rerr_q;

endmodule

// File: tb/tb_skew_cal_seq.sv
// Bench for skew_cal_seq with a behavioural measurement-unit stub.
module tb_skew_cal_seq;
    localparam int N_CH   = 8;
    localparam int CODE_W = 10;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              arstn, start, abort;
    logic [N_CH-1:0]   ch_mask;
    logic              busy, done;
    logic [CH_W-1:0]   ch_sel, rd_addr;
    logic [CODE_W-1:0] rd_code;
    logic [N_CH-1:0]   res_valid, res_err;

    skew_cal_seq_if #(.CODE_W(CODE_W)) mes ();

    skew_cal_seq #(
        .N_CH(N_CH), .CODE_W(CODE_W), .AVG_LOG2(2), .SETTLE_CYC(16), .TMO_CYC(100)
    ) dut (
        .clk_i(clk), .arstn_i(arstn), .start_i(start), .abort_i(abort),
        .ch_mask_i(ch_mask), .busy_o(busy), .done_o(done), .ch_sel_o(ch_sel),
        .rd_addr_i(rd_addr), .rd_code_o(rd_code), .res_valid_o(res_valid),
        .res_err_o(res_err), .mes(mes)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int          cyc = 0, run_rises = 0, done_cnt = 0, rise_cyc = 0, run_len = 0, last_ch = -1;
    logic        run_prev = 1'b0;
    logic [31:0] visit_sig = 32'h0;

    // Stub configuration and state
    int epoch = 0, stub_epoch = 0, hang_ch = -1, err_ch = -1, err_rep = -1;
    int rep [N_CH];
    int dly = 0;
    int c;

    always @(negedge clk) begin
        cyc++;
        if (mes.mes_run_o && !run_prev) begin
            run_rises++;
            rise_cyc = cyc;
            if (int'(ch_sel) != last_ch) begin
                visit_sig = {visit_sig[27:0], 1'b0, ch_sel};
                last_ch   = int'(ch_sel);
            end
        end
        if (!mes.mes_run_o && run_prev) run_len = cyc - rise_cyc;
        if (done) done_cnt++;
        run_prev = mes.mes_run_o;
    end

    // skew_mes_ctl model: answers ch*10+rep two cycles into a run, holds status until run drops.
    always @(negedge clk) begin
        if (epoch != stub_epoch) begin
            stub_epoch = epoch;
            foreach (rep[i]) rep[i] = 0;
        end
        if (!mes.mes_run_o) begin
            mes.mes_rdy_i = 1'b0;
            mes.mes_err_i = 1'b0;
            dly = 0;
        end else if (!mes.mes_rdy_i && !mes.mes_err_i) begin
            c = int'(ch_sel);
            if (c != hang_ch) begin
                if (dly < 2) begin
                    dly++;
                end else begin
                    if (c == err_ch && rep[c] == err_rep) begin
                        mes.mes_err_i = 1'b1;
                    end else begin
                        mes.mes_code_i = CODE_W'(c * 10 + rep[c]);
                        mes.mes_rdy_i  = 1'b1;
                    end
                    rep[c]++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still %0b after %0d cycles, expected 0", nm, busy, k);
        end
    endtask

    task automatic wait_run_ch(input int ch);
        int k;
        k = 0;
        while (!(mes.mes_run_o && int'(ch_sel) == ch) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_run_ch%0d: run=%0b ch_sel=%0d, expected run on ch %0d", ch, mes.mes_run_o, ch_sel, ch);
        end
    endtask

    task automatic pulse_start(input logic [N_CH-1:0] m);
        @(negedge clk);
        start   = 1'b1;
        ch_mask = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  mask;
        int          hang;
        int          ech;
        int          erep;
        logic [7:0]  exp_valid;
        logic [7:0]  exp_err;
        int          exp_runs;
        int          exp_dones;
        int          exp_runlen;
        logic [11:0] exp_vis;
        bit          chk_vis;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int r0, d0;

        vecs[0] = '{8'hFF, -1, -1, -1, 8'hFF, 8'h00, 32, 1, -1, 12'h000, 1'b0};
        vecs[1] = '{8'hA4, -1, -1, -1, 8'hA4, 8'h00, 12, 1, -1, 12'h257, 1'b1};
        vecs[2] = '{8'hFF, -1,  3,  1, 8'hF7, 8'h08, 30, 1, -1, 12'h000, 1'b0};
        vecs[3] = '{8'h03,  1, -1, -1, 8'h01, 8'h02,  5, 1, 100, 12'h000, 1'b0};
        vecs[4] = '{8'h00, -1, -1, -1, 8'h00, 8'h00,  0, 1, -1, 12'h000, 1'b0};

        arstn = 1'b1; start = 1'b0; abort = 1'b0; ch_mask = '0; rd_addr = '0;
        mes.gen_rdy_i = 1'b1;
        #2 arstn = 1'b0;
        #20;
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_run",   32'(mes.mes_run_o), 32'd0);
        chk("rst_chsel", 32'(ch_sel), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_err",   32'(res_err), 32'd0);
        chk("rst_code",  32'(rd_code), 32'd0);

        for (int i = 0; i < 5; i++) begin
            hang_ch = vecs[i].hang;
            err_ch  = vecs[i].ech;
            err_rep = vecs[i].erep;
            epoch++;
            r0 = run_rises;
            d0 = done_cnt;
            pulse_start(vecs[i].mask);
            wait_idle($sformatf("v%0d_idle", i));
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 32'(res_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_err", i),   32'(res_err),   32'(vecs[i].exp_err));
            chk($sformatf("v%0d_runs", i),  run_rises - r0, vecs[i].exp_runs);
            chk($sformatf("v%0d_dones", i), done_cnt - d0,  vecs[i].exp_dones);
            if (vecs[i].exp_runlen >= 0)
                chk($sformatf("v%0d_runlen", i), run_len, vecs[i].exp_runlen);
            if (vecs[i].chk_vis)
                chk($sformatf("v%0d_visit", i), 32'(visit_sig[11:0]), 32'(vecs[i].exp_vis));
            for (int ch = 0; ch < N_CH; ch++) begin
                if (vecs[i].exp_valid[ch]) begin
                    rd_addr = CH_W'(ch);
                    #1;
                    chk($sformatf("v%0d_code%0d", i, ch), 32'(rd_code), ch * 10 + 2);
                end
            end
        end
        hang_ch = -1; err_ch = -1; err_rep = -1;
        rd_addr = '0;

        // Zero mask: IDLE -> SEL -> DONE
        @(negedge clk);
        start = 1'b1; ch_mask = '0;
        @(negedge clk);
        start = 1'b0;
        chk("zm_busy_sel", 32'(busy), 32'd1);
        chk("zm_done_sel", 32'(done), 32'd0);
        @(negedge clk);
        chk("zm_done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        chk("zm_done_end", 32'(done), 32'd0);
        chk("zm_busy_end", 32'(busy), 32'd0);

        // gen_rdy low holds off the run; a start while busy is ignored
        mes.gen_rdy_i = 1'b0;
        epoch++;
        r0 = run_rises;
        d0 = done_cnt;
        pulse_start(8'h01);
        repeat (200) @(negedge clk);
        chk("gen_low_runs", run_rises - r0, 0);
        chk("gen_low_busy", 32'(busy), 32'd1);
        pulse_start(8'hFF);
        mes.gen_rdy_i = 1'b1;
        wait_idle("gen_low_idle");
        @(negedge clk);
        chk("busy_start_valid", 32'(res_valid), 32'h01);
        chk("busy_start_runs",  run_rises - r0, 4);
        chk("busy_start_dones", done_cnt - d0, 1);

        // Abort during ch2 RUN
        epoch++;
        d0 = done_cnt;
        pulse_start(8'hFF);
        wait_run_ch(2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_run",   32'(mes.mes_run_o), 32'd0);
        chk("abort_valid", 32'(res_valid), 32'h03);
        chk("abort_err",   32'(res_err), 32'h00);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_code0", 32'(rd_code), 32'd2);

        // Async reset during ch2 RUN
        epoch++;
        pulse_start(8'hFF);
        wait_run_ch(2);
        arstn = 1'b0;
        #1;
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_done",  32'(done), 32'd0);
        chk("arst_run",   32'(mes.mes_run_o), 32'd0);
        chk("arst_chsel", 32'(ch_sel), 32'd0);
        chk("arst_valid", 32'(res_valid), 32'd0);
        chk("arst_err",   32'(res_err), 32'd0);
        chk("arst_code",  32'(rd_code), 32'd0);
        @(negedge clk);
        arstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/skew_cal_seq.md
# skew_cal_seq

Calibration sequencer for the measure unit. It walks a masked set of comparator channels through the shared `skew_mes_ctl` / `stb_gen` pair. For each channel it selects the channel on the analog mux, runs 2^AVG_LOG2 skew measurements, averages the returned delay codes and stores one rounded code plus status per channel for software readout.

## Interface
- `N_CH`, 8: number of channels; CH_W = $clog2(N_CH).
- `CODE_W`, 10: delay-code width, matching `skew_mes_ctl`.
- `AVG_LOG2`, 2: log2 of measurements per channel (0..4).
- `SETTLE_CYC`, 16: cycles waited after a mux change before checking the strobe generator.
- `TMO_CYC`, 2^20-1: cycles allowed per measurement before a timeout.

Ports:
- `clk_i` in 1: system clock. One clock; reset is asynchronous and active-low.
- `arstn_i` in 1: async active-low reset.
- `start_i` in 1: start pulse; sampled only in IDLE.
- `abort_i` in 1: abort the sweep; acts in any state.
- `ch_mask_i` in N_CH: channels to calibrate; sampled with `start_i`.
- `busy_o` out 1: sweep in progress.
- `done_o` out 1: one-cycle pulse at sweep end.
- `mes_run_o` out 1: run level to `skew_mes_ctl`.
- `mes_rdy_i` in 1: measurement complete level.
- `mes_err_i` in 1: measurement error level.
- `mes_code_i` in CODE_W: measured delay code; valid while `mes_rdy_i` is high.
- `gen_rdy_i` in 1: `stb_gen` locked to the signal period.
- `ch_sel_o` out CH_W: channel mux select.
- `rd_addr_i` in CH_W: result read address.
- `rd_code_o` out CODE_W: averaged code at `rd_addr_i`; combinational read.
- `res_valid_o` out N_CH: per-channel result-valid bitmap.
- `res_err_o` out N_CH: per-channel error bitmap.

## Operation
States: IDLE, SEL, SETTLE, WAIT_GEN, RUN, RELEASE, STORE, DONE.

- **IDLE**
  - With `start_i`=1: latch the mask, clear `res_valid_o` and `res_err_o`, go to SEL.
- **SEL**
  - Find the lowest set bit of the remaining mask.
  - If none is set, go to DONE.
  - Otherwise drive `ch_sel_o` with that channel, clear the accumulator and rep counter, load the settle counter, go to SETTLE.
- **SETTLE**
  - Count SETTLE_CYC cycles, then go to WAIT_GEN.
- **WAIT_GEN**
  - When `gen_rdy_i`=1, go to RUN and reload the timeout counter.
- **RUN**
  - `mes_run_o`=1.
  - On `mes_rdy_i`: add `mes_code_i` to the accumulator, increment the rep counter, go to RELEASE.
  - On `mes_err_i`, or when the timeout counter expires: set the channel's error flag, go to RELEASE.
  - If `mes_rdy_i` and `mes_err_i` are high in the same cycle, the error wins.
- **RELEASE**
  - `mes_run_o`=0.
  - Wait until `mes_rdy_i`=0 and `mes_err_i`=0.
  - Then go to RUN if reps remain and the channel has no error; otherwise go to STORE.
- **STORE**
  - If the channel has no error: write the rounded average to `rd_code_o` storage and set `res_valid_o[ch]`.
  - If the channel has an error: set `res_err_o[ch]` and write nothing.
  - Clear the channel's bit in the remaining mask, go to SEL.
- **DONE**
  - `done_o`=1 for one cycle, go to IDLE.

Arithmetic:
- The accumulator is CODE_W+AVG_LOG2 bits and cannot overflow.
- Average = (acc + 2^(AVG_LOG2-1)) >> AVG_LOG2, i.e. round half up. With AVG_LOG2=0 the average is acc. The result never exceeds 2^CODE_W-1.

Abort:
- `abort_i` in any state forces IDLE on the next edge with `mes_run_o`=0 and no `done_o`.
- Channels already stored keep their valid and error bits.

## Timing
- Reset values: state IDLE, all outputs 0, result storage 0, `ch_sel_o`=0.
- `busy_o` is 1 in every state except IDLE. It rises the cycle after `start_i` is accepted and falls the cycle after DONE.
- `start_i` while busy is ignored.
- `start_i` with an all-zero mask gives the sequence IDLE→SEL→DONE: `done_o` pulses 2 cycles after start, and `mes_run_o` never rises.
- `mes_run_o` is registered:
  - It rises on the first cycle of RUN.
  - Minimum low time between runs is 1 cycle, and is extended until `skew_mes_ctl` drops its status outputs.
- `ch_sel_o` changes only in SEL. It is stable from SETTLE through STORE.
- `res_valid_o` / `res_err_o` bits update on the STORE edge. `rd_code_o` reflects a new value in the cycle after STORE.
- The timeout counter runs only in RUN. Expiry happens TMO_CYC cycles after entering RUN.
- If `gen_rdy_i` drops during RUN, measurement continues; only the timeout covers a hang.
- Async reset mid-sweep returns to reset values immediately; results are lost.

## Structure
- Package `skew_cal_pkg`:
  - `state_t` enum.
  - `res_t` struct {code, valid, err}.
  - Rounding function `avg_round(acc, log2)`.
- Sub-module `skew_cal_acc`: accumulator, rep counter, rounding. Ports: clear, add, code, result, reps_done.
- Channel selection uses a priority encoder over the remaining mask, written inline.
- Result storage is a flop array of N_CH×CODE_W, not a RAM.

## Test plan
- **Full sweep.** Mask 8'hFF with a behavioural `skew_mes_ctl` returning codes ch*10+{0,1,2,3}.
  - Expect `rd_code_o`[ch] = ch*10+2, since (6+2)>>2 = 2.
  - Expect `res_valid_o`=8'hFF, `res_err_o`=0, and one `done_o` pulse.
- **Sparse mask.** Mask 8'b1010_0100.
  - `ch_sel_o` visits 2, 5, 7 in order.
  - Unmasked channels stay valid=0.
  - Exactly 12 `mes_run_o` rising edges.
- **Error mid-channel.** Assert `mes_err_i` on the 2nd rep of ch3.
  - `res_err_o[3]`=1, `res_valid_o[3]`=0, no 3rd rep on ch3.
  - ch4 proceeds normally.
- **Timeout.** Stub never answers on ch1 (TMO_CYC=100).
  - `mes_run_o` falls 100 cycles after it rose.
  - `res_err_o[1]`=1 and the sweep completes.
- **Start behaviour.**
  - `gen_rdy_i` held low: `mes_run_o` stays 0 indefinitely.
  - `start_i` while busy: ignored.
  - Zero mask: `done_o` 2 cycles after start.
- **Abort and reset.** Pulse `abort_i` during ch2 RUN.
  - Next cycle: IDLE, `mes_run_o`=0, no `done_o`, ch0/ch1 stay valid.
  - Repeat with `arstn_i` low: all outputs return to 0.
